// File: rtl/xp_out_sched.sv
// Output-port scheduler for one XP port: round-robin across requesters, gated by per-VC credits.
// Optional XP_SCHED_CREDIT_CHK_EN enables the sticky credit overflow/underflow flag.
module xp_out_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_VC     = 4,
    parameter int unsigned CREDIT_MAX = 8,
    localparam int unsigned SEL_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CREDIT_COUNT_WIDTH = $clog2(CREDIT_MAX + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*4-1:0]          req_vc,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SEL_W-1:0]              out_sel,
    output logic [3:0]                    out_vc_id,
    input  logic                          credit_return,
    input  logic [3:0]                    credit_return_vc,
    output logic [CREDIT_COUNT_WIDTH-1:0] credit_count,
    output logic                          err_credit_ovf
);

    localparam int unsigned CW = CREDIT_COUNT_WIDTH;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t             state, state_n;
    logic [SEL_W-1:0]   sel_n, rr_ptr, rr_n, sel_inc, base, winner;
    logic [3:0]         vc_id_n, win_vc;
    logic [CW-1:0]      cnt [NUM_VC];
    logic [NUM_VC-1:0]  dec_v, inc_v, vc_ok;
    logic [NUM_REQ-1:0] elig;
    logic [2*NUM_REQ-1:0] rot;
    logic               complete, found;
    int unsigned        off, wsum;

    assign complete  = (state == HOLD) && out_ready;
    assign out_valid = (state == HOLD);

    // Per-VC credit updates; effective credit excludes the VC of a transfer completing now
    always_comb begin
        for (int v = 0; v < int'(NUM_VC); v++) begin
            dec_v[v] = complete && (out_vc_id == 4'(v));
            inc_v[v] = credit_return && (credit_return_vc == 4'(v));
            vc_ok[v] = cnt[v] > (dec_v[v] ? CW'(1) : CW'(0));
        end
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            for (int v = 0; v < int'(NUM_VC); v++) begin
                if (req_valid[i] && (req_vc[4*i +: 4] == 4'(v)) && vc_ok[v]) begin
                    elig[i] = 1'b1;
                end
            end
        end
    end

    // Round-robin search: rotate so bit 0 is the starting requester, take the first set bit
    always_comb begin
        sel_inc = (32'(out_sel) + 32'd1 >= NUM_REQ) ? '0 : out_sel + SEL_W'(1);
        base    = complete ? sel_inc : rr_ptr;
        rot     = {elig, elig} >> base;
        found   = 1'b0;
        off     = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        wsum = 32'(base) + off;
        if (wsum >= NUM_REQ) begin
            wsum = wsum - NUM_REQ;
        end
        winner = SEL_W'(wsum);
        win_vc = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (SEL_W'(i) == winner) begin
                win_vc = req_vc[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = out_sel;
        vc_id_n = out_vc_id;
        rr_n    = rr_ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = HOLD;
                    sel_n   = winner;
                    vc_id_n = win_vc;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    rr_n = sel_inc;
                    if (found) begin
                        sel_n   = winner;
                        vc_id_n = win_vc;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_sel   <= '0;
            out_vc_id <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_n;
            out_sel   <= sel_n;
            out_vc_id <= vc_id_n;
            rr_ptr    <= rr_n;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready[i] = complete && (SEL_W'(i) == out_sel);
        end
    end

    // Saturating counters; simultaneous return and consume cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < int'(NUM_VC); v++) begin
                cnt[v] <= CW'(CREDIT_MAX);
            end
        end else begin
            for (int v = 0; v < int'(NUM_VC); v++) begin
                if (inc_v[v] && !dec_v[v] && (cnt[v] != CW'(CREDIT_MAX))) begin
                    cnt[v] <= cnt[v] + CW'(1);
                end else if (dec_v[v] && !inc_v[v] && (cnt[v] != '0)) begin
                    cnt[v] <= cnt[v] - CW'(1);
                end
            end
        end
    end

    always_comb begin
        credit_count = '0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (out_vc_id == 4'(v)) begin
                credit_count = cnt[v];
            end
        end
    end

`ifdef XP_SCHED_CREDIT_CHK_EN
    logic credit_evt;

    always_comb begin
        credit_evt = 1'b0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (inc_v[v] && !dec_v[v] && (cnt[v] == CW'(CREDIT_MAX))) credit_evt = 1'b1;
            if (dec_v[v] && !inc_v[v] && (cnt[v] == '0)) credit_evt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_credit_ovf <= 1'b0;
        end else if (credit_evt) begin
            err_credit_ovf <= 1'b1;
        end
    end
`else
    assign err_credit_ovf = 1'b0;
`endif

endmodule

// File: doc/xp_out_sched.md
XP_OUT_SCHED -- requirements
Module: xp_out_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one XP output port.
REQ-002 SHALL have parameter NUM_VC, default 4, number of virtual channels (max 16).
REQ-003 SHALL have parameter CREDIT_MAX, default 8, per-VC reset credit value (fits CREDIT_COUNT_WIDTH).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  requester i has a flit pending.
REQ-007 SHALL have port req_vc  input  NUM_REQ*4  VC of requester i's flit, bits [4i+3:4i].
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot; requester i's flit is consumed this cycle.
REQ-009 SHALL have port out_valid  output  1  valid toward the XP port master.
REQ-010 SHALL have port out_ready  input  1  ready from the XP port.
REQ-011 SHALL have port out_sel  output  $clog2(NUM_REQ)  index of the granted requester, drives the flit mux.
REQ-012 SHALL have port out_vc_id  output  4  VC of the granted flit.
REQ-013 SHALL have port credit_return  input  1  one credit returned from downstream.
REQ-014 SHALL have port credit_return_vc  input  4  VC of the returned credit.
REQ-015 SHALL have port credit_count  output  CREDIT_COUNT_WIDTH  current credits of out_vc_id.
REQ-016 SHALL have port err_credit_ovf  output  1  sticky credit overflow/underflow error.

Function
REQ-017 SHALL implement a two-state FSM: IDLE (no grant held) and HOLD (grant registered, out_valid=1).
REQ-018 Requester i is eligible when req_valid[i]=1, req_vc[i]<NUM_VC, and the effective credits of its VC are >0.
REQ-019 Effective credits SHALL be the registered count minus 1 for the VC of a transfer completing this cycle.
REQ-020 In IDLE with >=1 eligible requester: register the round-robin winner, latch out_sel and out_vc_id, and enter HOLD next cycle.
REQ-021 Round-robin SHALL search from rr_ptr upward with wrap-around; rr_ptr SHALL become winner+1 mod NUM_REQ on each completed transfer.
REQ-022 In HOLD, out_valid, out_sel and out_vc_id SHALL be held stable until out_valid&&out_ready.
REQ-023 req_ready[out_sel] SHALL be 1 only in the completing cycle (combinational from HOLD&&out_ready); all other bits 0.
REQ-024 On completion, if any requester is eligible (REQ-019), the next winner SHALL be registered and HOLD kept, allowing back-to-back transfers at one per cycle; otherwise go to IDLE.
REQ-025 The credit counter of out_vc_id SHALL decrement on completion and increment on credit_return for credit_return_vc.
REQ-026 A simultaneous decrement and increment on the same VC SHALL leave the count unchanged.
REQ-027 An increment at CREDIT_MAX SHALL saturate, and a decrement at 0 SHALL hold at 0; either event is an error (REQ-033).
REQ-028 A requester dropping req_valid while granted SHALL NOT change out_valid; the requester protocol forbids this.
REQ-029 Latency from an eligible request in IDLE to out_valid SHALL be 1 cycle.

Reset
REQ-030 While rst=1: FSM=IDLE, out_valid=0, req_ready=0, out_sel=0, out_vc_id=0, rr_ptr=0, all credit counters=CREDIT_MAX, err_credit_ovf=0; the reset value of credit_count is CREDIT_MAX.
REQ-031 Reset asserted mid-HOLD SHALL drop out_valid asynchronously; the in-flight grant is discarded and no credit is consumed.
REQ-032 After rst deasserts, arbitration SHALL resume on the first rising clk edge.

Configuration
REQ-033 With XP_SCHED_CREDIT_CHK_EN defined, err_credit_ovf SHALL set on any REQ-027 event and hold until reset.
REQ-034 Without XP_SCHED_CREDIT_CHK_EN, err_credit_ovf SHALL be tied 0, with saturation behaviour unchanged.

Verification
REQ-035 After reset, req_valid=4'b0001 and VC0 -> out_valid next cycle with out_sel=0 and out_vc_id=0; with out_ready=1, req_ready=4'b0001 and credit_count=7 the following cycle.
REQ-036 All 4 requesters valid on VC1 and out_ready=1 held -> grants in order 0,1,2,3,0,... with one transfer per cycle.
REQ-037 VC2 drained to 0 credits and requesters 0 (VC2) and 1 (VC3) valid -> only requester 1 is granted; after credit_return on VC2, requester 0 is granted.
REQ-038 Completion on VC0 and credit_return on VC0 in the same cycle -> VC0 count unchanged.
REQ-039 With the macro defined, credit_return on VC3 at 8 credits -> count stays 8 and err_credit_ovf=1 until rst.
REQ-040 rst asserted during HOLD with out_ready=0 -> out_valid=0 immediately and all credits=8; req_ready never pulses.
